// File: rtl/fsk_symbol_mapper_pkg.sv
// -----------------------------------------------------------------------------
// fsk_pkg
// Shared definitions for the M-FSK symbol mapper:
//   fsk_state_t  - mapper FSM states (carrier off / carrier on)
//   gray2bin     - Gray-to-binary decode, up to 16-bit symbols (zero-extend input)
//   tone_offset  - symbol index k -> signed tone offset (2k-(M-1))*(STEP/2)
//   min_freq_w   - narrowest signed width holding +/-(M-1)*STEP/2
// -----------------------------------------------------------------------------
package fsk_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsk_state_t;

    localparam int unsigned GRAY_MAX_W = 16;

    // Each binary bit is the XOR of all Gray bits at or above its position.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int unsigned i = GRAY_MAX_W - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

    function automatic int tone_offset(input int k, input int m, input int step);
        return (2 * k - (m - 1)) * (step / 2);
    endfunction

    // Positive extreme is the binding constraint for two's complement.
    function automatic int unsigned min_freq_w(input int unsigned m, input int unsigned step);
        int unsigned mag;
        mag = ((m - 1) * step) / 2;
        for (int unsigned w = 1; w < 32; w++) begin
            if (((32'd1 << (w - 1)) - 32'd1) >= mag) begin
                return w;
            end
        end
        return 32;
    endfunction

endpackage

// File: rtl/fsk_symbol_mapper_beat_packer.sv
// -----------------------------------------------------------------------------
// fsk_beat_packer
// Packs IN_W-bit beats (MSB beat first) into BITS_PER_SYM-bit symbols.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid, datain  qualified input beat
//   sym_sync          restart alignment; a same-cycle beat becomes beat 0
//   flush             discard any partial symbol (carrier drop)
//   sym               symbol including the current beat (valid with sym_done)
//   sym_done          this edge completes a symbol
// -----------------------------------------------------------------------------
module fsk_beat_packer #(
    parameter int unsigned IN_W         = 2,
    parameter int unsigned BITS_PER_SYM = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [IN_W-1:0]         datain,
    input  logic                    sym_sync,
    input  logic                    flush,
    output logic [BITS_PER_SYM-1:0] sym,
    output logic                    sym_done
);

    localparam int unsigned BEATS = BITS_PER_SYM / IN_W;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [BITS_PER_SYM-1:0] sr;
    logic [BITS_PER_SYM-1:0] sr_base;
    logic [BW-1:0]           beat;
    logic [BW-1:0]           beat_base;

    // sym_sync rebases alignment before the current beat is taken, so the
    // same-cycle beat lands as beat 0 of a fresh symbol.
    always_comb begin
        beat_base = sym_sync ? '0 : beat;
        sr_base   = sym_sync ? '0 : sr;
        sym       = BITS_PER_SYM'({sr_base, datain});
        sym_done  = in_valid && (beat_base == BW'(BEATS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            beat <= '0;
        end else if (flush) begin
            sr   <= '0;
            beat <= '0;
        end else if (in_valid) begin
            sr   <= sym;
            beat <= sym_done ? '0 : beat_base + 1'b1;
        end else if (sym_sync) begin
            sr   <= '0;
            beat <= '0;
        end
    end

endmodule

// File: rtl/fsk_symbol_mapper.sv
// -----------------------------------------------------------------------------
// fsk_symbol_mapper
// M-FSK symbol mapper: packs input beats into symbols, optionally Gray-decodes,
// and drives the NCO with a signed tone offset. Drops the carrier after
// IDLE_CYC consecutive cycles without input.
// Ports:
//   clk_load    sample clock (rising edge)
//   rst         asynchronous active-low reset
//   in_valid    datain qualifies this cycle
//   datain      IN_W-bit input beat
//   sym_sync    restart symbol alignment
//   gray_en     Gray-decode symbol before mapping (sampled on completion)
//   freq        signed tone offset, FREQ_W bits
//   sym_valid   one-cycle pulse when freq takes a new symbol
//   carrier_on  high while a tone is transmitted
//   data_read   raw bits of the last mapped symbol
//   sym_count   mapped-symbol counter (wraps)
// -----------------------------------------------------------------------------
module fsk_symbol_mapper
    import fsk_pkg::*;
#(
    parameter int unsigned IN_W         = 2,
    parameter int unsigned BITS_PER_SYM = 4,
    parameter int unsigned FREQ_W       = 8,
    parameter int unsigned STEP         = 4,
    parameter int unsigned IDLE_CYC     = 64
) (
    input  logic                    clk_load,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [IN_W-1:0]         datain,
    input  logic                    sym_sync,
    input  logic                    gray_en,
    output logic [FREQ_W-1:0]       freq,
    output logic                    sym_valid,
    output logic                    carrier_on,
    output logic [BITS_PER_SYM-1:0] data_read,
    output logic [15:0]             sym_count
);

    localparam int unsigned M   = 32'd1 << BITS_PER_SYM;
    localparam int unsigned ICW = $clog2(IDLE_CYC);
    localparam logic [ICW-1:0] IDLE_MAX = ICW'(IDLE_CYC - 1);

    if (BITS_PER_SYM % IN_W != 0) begin : g_chk_div
        $error("BITS_PER_SYM must be a multiple of IN_W");
    end
    if ((STEP % 2 != 0) || (STEP < 2)) begin : g_chk_step
        $error("STEP must be even and >= 2");
    end
    if (BITS_PER_SYM > GRAY_MAX_W) begin : g_chk_bps
        $error("BITS_PER_SYM exceeds gray2bin width");
    end
    if (FREQ_W < min_freq_w(M, STEP)) begin : g_chk_freq_w
        $error("FREQ_W too narrow for tone range");
    end
    if (IDLE_CYC < 2) begin : g_chk_idle
        $error("IDLE_CYC must be >= 2");
    end

    fsk_state_t              state;
    logic [ICW-1:0]          idle_cnt;
    logic [BITS_PER_SYM-1:0] sym;
    logic                    sym_done;
    logic                    flush;
    logic [BITS_PER_SYM-1:0] k;
    logic [FREQ_W-1:0]       tone;

    // Flush only ever fires on an empty cycle, so it never races a completion.
    assign flush = (state == S_RUN) && !in_valid && (idle_cnt == IDLE_MAX);

    fsk_beat_packer #(
        .IN_W         (IN_W),
        .BITS_PER_SYM (BITS_PER_SYM)
    ) u_packer (
        .clk      (clk_load),
        .rst_n    (rst),
        .in_valid (in_valid),
        .datain   (datain),
        .sym_sync (sym_sync),
        .flush    (flush),
        .sym      (sym),
        .sym_done (sym_done)
    );

    always_comb begin
        k    = gray_en ? BITS_PER_SYM'(gray2bin(GRAY_MAX_W'(sym))) : sym;
        tone = FREQ_W'(tone_offset(int'(k), int'(M), int'(STEP)));
    end

    always_ff @(posedge clk_load or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            idle_cnt   <= '0;
            freq       <= '0;
            sym_valid  <= 1'b0;
            carrier_on <= 1'b0;
            data_read  <= '0;
            sym_count  <= '0;
        end else begin
            sym_valid <= 1'b0;

            if (in_valid) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (sym_done) begin
                state      <= S_RUN;
                freq       <= tone;
                sym_valid  <= 1'b1;
                carrier_on <= 1'b1;
                data_read  <= sym;
                sym_count  <= sym_count + 16'd1;
            end else if (flush) begin
                state      <= S_IDLE;
                freq       <= '0;
                carrier_on <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fsk_symbol_mapper.sv
// -----------------------------------------------------------------------------
// tb_fsk_symbol_mapper
// Directed vector table, reset / counter-wrap sequences and randomized
// traffic checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fsk_symbol_mapper;

    localparam int IN_W     = 2;
    localparam int BPS      = 4;
    localparam int FREQ_W   = 8;
    localparam int STEP     = 4;
    localparam int IDLE_CYC = 8;
    localparam int M        = 16;
    localparam int BEATS    = BPS / IN_W;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [IN_W-1:0]   datain;
    logic              sym_sync;
    logic              gray_en;
    logic [FREQ_W-1:0] freq;
    logic              sym_valid;
    logic              carrier_on;
    logic [BPS-1:0]    data_read;
    logic [15:0]       sym_count;

    fsk_symbol_mapper #(
        .IN_W         (IN_W),
        .BITS_PER_SYM (BPS),
        .FREQ_W       (FREQ_W),
        .STEP         (STEP),
        .IDLE_CYC     (IDLE_CYC)
    ) dut (
        .clk_load   (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .datain     (datain),
        .sym_sync   (sym_sync),
        .gray_en    (gray_en),
        .freq       (freq),
        .sym_valid  (sym_valid),
        .carrier_on (carrier_on),
        .data_read  (data_read),
        .sym_count  (sym_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int          q[$];
    logic [7:0]  m_freq;
    bit          m_sv;
    bit          m_car;
    logic [3:0]  m_dr;
    logic [15:0] m_cnt;
    int          m_idle;
    bit          m_run;

    function automatic int g2b(input int g);
        int b;
        b = g;
        for (int sh = 1; sh < BPS; sh++) b = b ^ (g >> sh);
        return b & (M - 1);
    endfunction

    task automatic model_reset();
        q.delete();
        m_freq = '0; m_sv = 0; m_car = 0; m_dr = '0; m_cnt = '0;
        m_idle = 0; m_run = 0;
    endtask

    task automatic model_edge(input bit v, input logic [1:0] d, input bit s, input bit g);
        int sym;
        int k;
        bit done;
        done = 0;
        sym  = 0;
        if (s) q.delete();
        if (v) begin
            q.push_back(int'(d));
            if (q.size() == BEATS) begin
                foreach (q[i]) sym = sym * (1 << IN_W) + q[i];
                q.delete();
                done = 1;
            end
        end
        m_sv = done;
        if (v) m_idle = 0; else m_idle++;
        if (done) begin
            k      = g ? g2b(sym) : sym;
            m_freq = 8'((2 * k - (M - 1)) * (STEP / 2));
            m_dr   = 4'(sym);
            m_cnt  = m_cnt + 16'd1;
            m_car  = 1;
            m_run  = 1;
        end else if (m_run && m_idle >= IDLE_CYC) begin
            m_run  = 0;
            m_car  = 0;
            m_freq = '0;
            q.delete();
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit v, input logic [1:0] d, input bit s, input bit g);
        in_valid = v; datain = d; sym_sync = s; gray_en = g;
        @(posedge clk);
        model_edge(v, d, s, g);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".freq"},       32'(freq),       32'(m_freq));
        chk({tag, ".sym_valid"},  32'(sym_valid),  32'(m_sv));
        chk({tag, ".carrier_on"}, 32'(carrier_on), 32'(m_car));
        chk({tag, ".data_read"},  32'(data_read),  32'(m_dr));
        chk({tag, ".sym_count"},  32'(sym_count),  32'(m_cnt));
    endtask

    typedef struct {
        bit          v;
        logic [1:0]  d;
        bit          s;
        bit          g;
        logic [7:0]  f;
        bit          sv;
        bit          car;
        logic [3:0]  dr;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit v, input logic [1:0] d, input bit s, input bit g,
                       input logic [7:0] f, input bit sv, input bit car,
                       input logic [3:0] dr, input logic [15:0] cnt);
        vec_t r;
        r.v = v; r.d = d; r.s = s; r.g = g; r.f = f; r.sv = sv; r.car = car;
        r.dr = dr; r.cnt = cnt;
        tbl.push_back(r);
    endtask

    initial begin
        // inputs, then freq / sym_valid / carrier_on / data_read / sym_count after the edge
        add(1, 2'b00, 0, 0, 8'h00, 0, 0, 4'h0, 16'd0);
        add(1, 2'b00, 0, 0, 8'hE2, 1, 1, 4'h0, 16'd1);
        add(0, 2'b00, 0, 0, 8'hE2, 0, 1, 4'h0, 16'd1);
        add(1, 2'b11, 0, 0, 8'hE2, 0, 1, 4'h0, 16'd1);
        add(1, 2'b11, 0, 0, 8'h1E, 1, 1, 4'hF, 16'd2);
        add(1, 2'b10, 0, 0, 8'h1E, 0, 1, 4'hF, 16'd2);
        add(1, 2'b00, 0, 0, 8'h02, 1, 1, 4'h8, 16'd3);
        add(1, 2'b00, 0, 1, 8'h02, 0, 1, 4'h8, 16'd3);
        add(1, 2'b10, 0, 1, 8'hEE, 1, 1, 4'h2, 16'd4);
        add(1, 2'b11, 0, 0, 8'hEE, 0, 1, 4'h2, 16'd4);
        add(1, 2'b01, 1, 0, 8'hEE, 0, 1, 4'h2, 16'd4);
        add(1, 2'b10, 0, 0, 8'hFA, 1, 1, 4'h6, 16'd5);
        add(1, 2'b01, 0, 0, 8'hFA, 0, 1, 4'h6, 16'd5);
        for (int i = 0; i < IDLE_CYC - 1; i++)
            add(0, 2'b00, 0, 0, 8'hFA, 0, 1, 4'h6, 16'd5);
        add(0, 2'b00, 0, 0, 8'h00, 0, 0, 4'h6, 16'd5);
        add(1, 2'b11, 0, 0, 8'h00, 0, 0, 4'h6, 16'd5);
        add(1, 2'b11, 0, 0, 8'h1E, 1, 1, 4'hF, 16'd6);

        rst = 1'b0; in_valid = 1'b0; datain = '0; sym_sync = 1'b0; gray_en = 1'b0;
        model_reset();
        #12;
        chk("reset.freq",       32'(freq),       32'h00);
        chk("reset.sym_valid",  32'(sym_valid),  32'h0);
        chk("reset.carrier_on", 32'(carrier_on), 32'h0);
        chk("reset.data_read",  32'(data_read),  32'h0);
        chk("reset.sym_count",  32'(sym_count),  32'h0);
        #1 rst = 1'b1;

        // directed table
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].g);
            chk($sformatf("tbl%0d.freq", i),       32'(freq),       32'(tbl[i].f));
            chk($sformatf("tbl%0d.sym_valid", i),  32'(sym_valid),  32'(tbl[i].sv));
            chk($sformatf("tbl%0d.carrier_on", i), 32'(carrier_on), 32'(tbl[i].car));
            chk($sformatf("tbl%0d.data_read", i),  32'(data_read),  32'(tbl[i].dr));
            chk($sformatf("tbl%0d.sym_count", i),  32'(sym_count),  32'(tbl[i].cnt));
        end

        // reset mid-symbol discards the pending beat
        step(1, 2'b11, 0, 0);
        rst = 1'b0;
        #2;
        model_reset();
        chk("midrst.freq",       32'(freq),       32'h00);
        chk("midrst.carrier_on", 32'(carrier_on), 32'h0);
        chk("midrst.sym_count",  32'(sym_count),  32'h0);
        #1 rst = 1'b1;
        step(1, 2'b01, 0, 0);
        chk("postrst_beat0.sym_valid", 32'(sym_valid), 32'h0);
        step(1, 2'b01, 0, 0);
        chk("postrst.freq",      32'(freq),      32'hF6);
        chk("postrst.sym_valid", 32'(sym_valid), 32'h1);
        chk("postrst.data_read", 32'(data_read), 32'h5);
        chk("postrst.sym_count", 32'(sym_count), 32'h1);

        // sym_count wrap via preload
        force dut.sym_count = 16'hFFFF;
        #1 release dut.sym_count;
        m_cnt = 16'hFFFF;
        step(1, 2'b00, 0, 0);
        step(1, 2'b00, 0, 0);
        chk("wrap.sym_count", 32'(sym_count), 32'h0);
        chk("wrap.freq",      32'(freq),      32'hE2);
        chk_model("wrap");

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                int gap;
                gap = int'($urandom_range(IDLE_CYC - 2, IDLE_CYC + 3));
                for (int j = 0; j < gap; j++) begin
                    step(0, 2'($urandom), 0, 1'($urandom));
                    chk_model($sformatf("gap%0d_%0d", n, j));
                end
            end else begin
                step(($urandom_range(0, 9) < 7), 2'($urandom),
                     ($urandom_range(0, 24) == 0), 1'($urandom));
                chk_model($sformatf("rnd%0d", n));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
